truth_table_sweeper: RTL and testbench

Sequencer that exhaustively exercises a 3-input combinational function block in hardware. On `start` it walks the inputs (x1,x2,x3) through all eight combinations in ascending binary order, waits a programmable settle time per vector, samples the function output `f`, and assembles an 8-bit truth table. It compares that table against a latched expected pattern and reports pass/fail, mismatch count and first failing vector. It sits between a top-level test/control FSM and the function-under-test (FUT), driving the FUT inputs directly.

---
 rtl/truth_table_sweeper.sv | 140 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive 3-input truth-table sweeper: drives a function-under-test through all
// eight input vectors, samples its output after a settle time and grades the table.
module truth_table_sweeper #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] expected_i,
    input  logic       f_in_i,
    output logic       x1_o,
    output logic       x2_o,
    output logic       x3_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] truth_o,
    output logic       pass_o,
    output logic [3:0] mismatch_count_o,
    output logic [2:0] first_fail_o
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       expected_q, expected_d;
    logic [7:0]       truth_q, truth_d;
    logic             pass_q, pass_d;
    logic [3:0]       mismatch_q, mismatch_d;
    logic [2:0]       first_fail_q, first_fail_d;

    logic [7:0]       truth_upd;
    logic [7:0]       diff;
    logic [3:0]       diff_count;
    logic [2:0]       diff_first;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            cnt_q        <= '0;
            expected_q   <= 8'h00;
            truth_q      <= 8'h00;
            pass_q       <= 1'b0;
            mismatch_q   <= 4'd0;
            first_fail_q <= 3'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            expected_q   <= expected_d;
            truth_q      <= truth_d;
            pass_q       <= pass_d;
            mismatch_q   <= mismatch_d;
            first_fail_q <= first_fail_d;
        end
    end

    // Grade the table including the sample taken on this edge, so the final
    // vector's result is already folded in when RUN hands over to DONE.
    always_comb begin
        truth_upd        = truth_q;
        truth_upd[idx_q] = f_in_i;
        diff             = truth_upd ^ expected_q;
        diff_count       = 4'd0;
        diff_first       = 3'd0;
        for (int i = 0; i < 8; i++) begin
            diff_count = diff_count + {3'b000, diff[i]};
        end
        for (int i = 7; i >= 0; i--) begin
            if (diff[i]) begin
                diff_first = 3'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        expected_d   = expected_q;
        truth_d      = truth_q;
        pass_d       = pass_q;
        mismatch_d   = mismatch_q;
        first_fail_d = first_fail_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d      = RUN;
                    expected_d   = expected_i;
                    truth_d      = 8'h00;
                    pass_d       = 1'b0;
                    mismatch_d   = 4'd0;
                    first_fail_d = 3'd0;
                    idx_d        = 3'd0;
                    cnt_d        = '0;
                end
            end
            RUN: begin
                if (cnt_q == CNT_MAX) begin
                    truth_d = truth_upd;
                    cnt_d   = '0;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d      = DONE;
                        pass_d       = (diff == 8'h00);
                        mismatch_d   = diff_count;
                        first_fail_d = diff_first;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign {x1_o, x2_o, x3_o} = (state_q == RUN) ? idx_q : 3'b000;
    assign busy_o             = (state_q == RUN);
    assign done_o             = (state_q == DONE);
    assign truth_o            = truth_q;
    assign pass_o             = pass_q;
    assign mismatch_count_o   = mismatch_q;
    assign first_fail_o       = first_fail_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: one instance at the default settle time
// driving x1&x2|~x3, one with zero settle time driving x1^x2^x3.
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst_n;

    logic       startA;
    logic [7:0] expA;
    logic       fA;
    logic       xa1, xa2, xa3;
    logic       busyA, doneA, passA;
    logic [7:0] truthA;
    logic [3:0] mcA;
    logic [2:0] ffA;

    logic       startB;
    logic [7:0] expB;
    logic       fB;
    logic       xb1, xb2, xb3;
    logic       busyB, doneB, passB;
    logic [7:0] truthB;
    logic [3:0] mcB;
    logic [2:0] ffB;

    int nCompared;
    int nMismatched;

    truth_table_sweeper #(.SETTLE_CYCLES(2)) dutA (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (startA),
        .expected_i       (expA),
        .f_in_i           (fA),
        .x1_o             (xa1),
        .x2_o             (xa2),
        .x3_o             (xa3),
        .busy_o           (busyA),
        .done_o           (doneA),
        .truth_o          (truthA),
        .pass_o           (passA),
        .mismatch_count_o (mcA),
        .first_fail_o     (ffA)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(0)) dutB (
        .clk              (clk),
        .rst_n            (rst_n),
        .start_i          (startB),
        .expected_i       (expB),
        .f_in_i           (fB),
        .x1_o             (xb1),
        .x2_o             (xb2),
        .x3_o             (xb3),
        .busy_o           (busyB),
        .done_o           (doneB),
        .truth_o          (truthB),
        .pass_o           (passB),
        .mismatch_count_o (mcB),
        .first_fail_o     (ffB)
    );

    assign fA = (xa1 & xa2) | ~xa3;
    assign fB = xb1 ^ xb2 ^ xb3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        startA = 1'b0;
        startB = 1'b0;
        expA   = 8'h00;
        expB   = 8'h00;
        #12;
        nCompared++;
        if ({xa1, xa2, xa3, busyA, doneA, passA, truthA, mcA, ffA} !== 22'd0) begin
            nMismatched++;
            $display("[TB] FAIL resetA: got x=%b%b%b busy=%b done=%b pass=%b truth=%h mc=%0d ff=%0d, want all zero",
                     xa1, xa2, xa3, busyA, doneA, passA, truthA, mcA, ffA);
        end
        nCompared++;
        if ({xb1, xb2, xb3, busyB, doneB, passB, truthB, mcB, ffB} !== 22'd0) begin
            nMismatched++;
            $display("[TB] FAIL resetB: got x=%b%b%b busy=%b done=%b pass=%b truth=%h mc=%0d ff=%0d, want all zero",
                     xb1, xb2, xb3, busyB, doneB, passB, truthB, mcB, ffB);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        nCompared++;
        if ({busyA, doneA} !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busyA, doneA);
        end
    endtask

    // Sweep on A with a given golden table; checks vector stepping, busy window,
    // the single done pulse and the graded results against hand-computed values.
    task automatic run_sweep_a(input logic [7:0] golden, input logic [7:0] wantTruth,
                               input logic wantPass, input logic [3:0] wantMc,
                               input logic [2:0] wantFf, input string tag);
        logic [2:0] wantX;
        startA = 1'b1;
        expA   = golden;
        tick();
        startA = 1'b0;
        nCompared++;
        if ({busyA, doneA, xa1, xa2, xa3, passA, truthA, mcA, ffA} !== {2'b10, 3'b000, 1'b0, 8'h00, 4'd0, 3'd0}) begin
            nMismatched++;
            $display("[TB] FAIL %s_accept: got busy=%b done=%b x=%b%b%b pass=%b truth=%h mc=%0d ff=%0d, want busy=1 cleared results",
                     tag, busyA, doneA, xa1, xa2, xa3, passA, truthA, mcA, ffA);
        end
        for (int e = 1; e <= 24; e++) begin
            tick();
            if (e < 24) begin
                wantX = 3'(e / 3);
                nCompared++;
                if ({busyA, doneA, xa1, xa2, xa3} !== {2'b10, wantX}) begin
                    nMismatched++;
                    $display("[TB] FAIL %s_run_e%0d: got busy=%b done=%b x=%b%b%b, want busy=1 done=0 x=%b",
                             tag, e, busyA, doneA, xa1, xa2, xa3, wantX);
                end
            end
        end
        nCompared++;
        if ({busyA, doneA, xa1, xa2, xa3} !== 5'b01000) begin
            nMismatched++;
            $display("[TB] FAIL %s_done: got busy=%b done=%b x=%b%b%b, want busy=0 done=1 x=000",
                     tag, busyA, doneA, xa1, xa2, xa3);
        end
        nCompared++;
        if ({truthA, passA, mcA, ffA} !== {wantTruth, wantPass, wantMc, wantFf}) begin
            nMismatched++;
            $display("[TB] FAIL %s_result: got truth=%h pass=%b mc=%0d ff=%0d, want truth=%h pass=%b mc=%0d ff=%0d",
                     tag, truthA, passA, mcA, ffA, wantTruth, wantPass, wantMc, wantFf);
        end
        tick();
        nCompared++;
        if ({busyA, doneA, truthA, passA, mcA, ffA} !== {2'b00, wantTruth, wantPass, wantMc, wantFf}) begin
            nMismatched++;
            $display("[TB] FAIL %s_hold: got busy=%b done=%b truth=%h pass=%b mc=%0d ff=%0d, want idle with held results",
                     tag, busyA, doneA, truthA, passA, mcA, ffA);
        end
    endtask

    task automatic test_pass_sweep();
        run_sweep_a(8'hD5, 8'hD5, 1'b1, 4'd0, 3'd0, "pass");
    endtask

    task automatic test_mismatch();
        run_sweep_a(8'hD4, 8'hD5, 1'b0, 4'd1, 3'd0, "mmD4");
        run_sweep_a(8'h15, 8'hD5, 1'b0, 4'd2, 3'd6, "mm15");
    endtask

    task automatic test_settle_zero();
        startB = 1'b1;
        expB   = 8'h69;
        tick();
        startB = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            if (e > 0) tick();
            if (e < 8) begin
                nCompared++;
                if ({busyB, doneB, xb1, xb2, xb3} !== {2'b10, 3'(e)}) begin
                    nMismatched++;
                    $display("[TB] FAIL s0_run_e%0d: got busy=%b done=%b x=%b%b%b, want busy=1 done=0 x=%0d",
                             e, busyB, doneB, xb1, xb2, xb3, e);
                end
            end
        end
        nCompared++;
        if ({busyB, doneB, truthB, passB, mcB, ffB} !== {2'b01, 8'h96, 1'b0, 4'd8, 3'd0}) begin
            nMismatched++;
            $display("[TB] FAIL s0_done: got busy=%b done=%b truth=%h pass=%b mc=%0d ff=%0d, want done truth=96 pass=0 mc=8 ff=0",
                     busyB, doneB, truthB, passB, mcB, ffB);
        end
        tick();
        nCompared++;
        if ({busyB, doneB} !== 2'b00) begin
            nMismatched++;
            $display("[TB] FAIL s0_idle: got busy=%b done=%b, want 0 0", busyB, doneB);
        end
    endtask

    // A second start during RUN and a later change of expected must not disturb the sweep.
    task automatic test_start_ignored();
        int doneCount;
        doneCount = 0;
        startA = 1'b1;
        expA   = 8'hD5;
        tick();
        startA = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            if (e == 5) startA = 1'b1;
            tick();
            if (e == 5) begin
                startA = 1'b0;
                expA   = 8'h00;
            end
            if (doneA) doneCount++;
            if (e == 23) begin
                nCompared++;
                if ({busyA, doneA, xa1, xa2, xa3} !== 5'b10111) begin
                    nMismatched++;
                    $display("[TB] FAIL ign_e23: got busy=%b done=%b x=%b%b%b, want busy=1 x=111",
                             busyA, doneA, xa1, xa2, xa3);
                end
            end
            if (e == 24) begin
                nCompared++;
                if ({doneA, passA, mcA, truthA} !== {1'b1, 1'b1, 4'd0, 8'hD5}) begin
                    nMismatched++;
                    $display("[TB] FAIL ign_done: got done=%b pass=%b mc=%0d truth=%h, want done=1 pass=1 mc=0 truth=d5",
                             doneA, passA, mcA, truthA);
                end
            end
        end
        nCompared++;
        if (doneCount !== 1) begin
            nMismatched++;
            $display("[TB] FAIL ign_done_count: got %0d done pulses, want 1", doneCount);
        end
        expA = 8'hD5;
    endtask

    task automatic test_reset_midsweep();
        int doneCount;
        startA = 1'b1;
        expA   = 8'hD5;
        tick();
        startA = 1'b0;
        for (int e = 1; e <= 10; e++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        nCompared++;
        if ({xa1, xa2, xa3, busyA, doneA, passA, truthA, mcA, ffA} !== 22'd0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_async: got x=%b%b%b busy=%b done=%b pass=%b truth=%h mc=%0d ff=%0d, want all zero",
                     xa1, xa2, xa3, busyA, doneA, passA, truthA, mcA, ffA);
        end
        tick();
        tick();
        rst_n = 1'b1;
        doneCount = 0;
        for (int e = 0; e < 30; e++) begin
            tick();
            if (doneA || busyA) doneCount++;
        end
        nCompared++;
        if (doneCount !== 0) begin
            nMismatched++;
            $display("[TB] FAIL midrst_quiet: got %0d busy/done cycles after reset, want 0", doneCount);
        end
        run_sweep_a(8'hD5, 8'hD5, 1'b1, 4'd0, 3'd0, "postrst");
    endtask

    // start held for 60 cycles: sweeps accepted at edges 0, 26, 52 with done after 24, 50, 76.
    task automatic test_back_to_back();
        logic wantBusy;
        logic wantDone;
        startA = 1'b1;
        expA   = 8'hD5;
        tick();
        for (int e = 1; e <= 80; e++) begin
            tick();
            if (e == 59) startA = 1'b0;
            wantDone = (e == 24) || (e == 50) || (e == 76);
            wantBusy = (e < 24) || (e >= 26 && e < 50) || (e >= 52 && e < 76);
            nCompared++;
            if ({busyA, doneA} !== {wantBusy, wantDone}) begin
                nMismatched++;
                $display("[TB] FAIL b2b_e%0d: got busy=%b done=%b, want busy=%b done=%b",
                         e, busyA, doneA, wantBusy, wantDone);
            end
            if (wantDone) begin
                nCompared++;
                if ({passA, truthA} !== {1'b1, 8'hD5}) begin
                    nMismatched++;
                    $display("[TB] FAIL b2b_result_e%0d: got pass=%b truth=%h, want pass=1 truth=d5",
                             e, passA, truthA);
                end
            end
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        test_reset();
        test_pass_sweep();
        test_mismatch();
        test_settle_zero();
        test_start_ignored();
        test_reset_midsweep();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
